// File: rtl/draw_engine_pkg.sv
// Shared constants for the draw engine and the game controller: ld_draw codes, geometry, colours, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package draw_engine_pkg;

   // Screen extent of the VGA adaptor
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   // Brick grid geometry
   localparam int BRICK_W   = 24;
   localparam int BRICK_H   = 6;
   localparam int BRICK_GAP = 2;
   localparam int BRICK_X0  = 2;
   localparam int BRICK_Y0  = 10;
   localparam int BRICKS_PER_ROW = 6;

   // Paddle and ball geometry
   localparam int PADDLE_W = 20;
   localparam int PADDLE_H = 3;
   localparam int PADDLE_Y = 112;
   localparam int BALL_SZ  = 2;

   // Old-position values after reset
   localparam logic [7:0] PADDLE_X_INIT = 8'd70;
   localparam logic [7:0] BALL_X_INIT   = 8'd79;
   localparam logic [6:0] BALL_Y_INIT   = 7'd100;

   // Colours
   localparam logic [2:0] BRICK_COL  = 3'b100;
   localparam logic [2:0] PADDLE_COL = 3'b111;
   localparam logic [2:0] BALL_COL   = 3'b010;
   localparam logic [2:0] BG_COL     = 3'b000;

   // ld_draw command codes shared with the controller
   localparam logic [4:0] CODE_NONE         = 5'd0;
   localparam logic [4:0] CODE_BRICK_FIRST  = 5'd1;
   localparam logic [4:0] CODE_BRICK_LAST   = 5'd12;
   localparam logic [4:0] CODE_ERASE_PADDLE = 5'd13;
   localparam logic [4:0] CODE_DRAW_PADDLE  = 5'd14;
   localparam logic [4:0] CODE_ERASE_BALL   = 5'd15;
   localparam logic [4:0] CODE_DRAW_BALL    = 5'd16;
   localparam logic [4:0] CODE_REMOVE_FIRST = 5'd17;
   localparam logic [4:0] CODE_REMOVE_LAST  = 5'd28;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/draw_engine_geom_lut.sv
// Resolves an ld_draw code plus current/old positions into a rectangle origin, size and colour.
// Latency: purely combinational.
// Backpressure: none; outputs only meaningful for codes 1..28.
module draw_geom_lut
   import draw_engine_pkg::*;
(
   input  logic [4:0] code,
   input  logic [7:0] paddle_x,
   input  logic [7:0] ball_x,
   input  logic [6:0] ball_y,
   input  logic [7:0] old_px,
   input  logic [7:0] old_bx,
   input  logic [6:0] old_by,
   output logic [7:0] x0,
   output logic [6:0] y0,
   output logic [7:0] w,
   output logic [6:0] h,
   output logic [2:0] colour
);

   logic [3:0] brick_k;
   logic [3:0] brick_col;
   logic [3:0] brick_row;

   // Zero-based brick index: draw codes 1..12 and remove codes 17..28 map to the same bricks
   assign brick_k   = (code <= CODE_BRICK_LAST) ? 4'(code - CODE_BRICK_FIRST) : 4'(code - CODE_REMOVE_FIRST);
   assign brick_col = brick_k % 4'(BRICKS_PER_ROW);
   assign brick_row = brick_k / 4'(BRICKS_PER_ROW);

   // Rectangle selection by code class
   always_comb begin
      x0     = 8'd0;
      y0     = 7'd0;
      w      = 8'd0;
      h      = 7'd0;
      colour = BG_COL;
      if ((code >= CODE_BRICK_FIRST && code <= CODE_BRICK_LAST) ||
          (code >= CODE_REMOVE_FIRST && code <= CODE_REMOVE_LAST)) begin
         x0     = 8'(BRICK_X0) + 8'(brick_col) * 8'(BRICK_W + BRICK_GAP);
         y0     = 7'(BRICK_Y0) + 7'(brick_row) * 7'(BRICK_H + BRICK_GAP);
         w      = 8'(BRICK_W);
         h      = 7'(BRICK_H);
         colour = (code <= CODE_BRICK_LAST) ? BRICK_COL : BG_COL;
      end else if (code == CODE_ERASE_PADDLE || code == CODE_DRAW_PADDLE) begin
         x0     = (code == CODE_DRAW_PADDLE) ? paddle_x : old_px;
         y0     = 7'(PADDLE_Y);
         w      = 8'(PADDLE_W);
         h      = 7'(PADDLE_H);
         colour = (code == CODE_DRAW_PADDLE) ? PADDLE_COL : BG_COL;
      end else if (code == CODE_ERASE_BALL || code == CODE_DRAW_BALL) begin
         x0     = (code == CODE_DRAW_BALL) ? ball_x : old_bx;
         y0     = (code == CODE_DRAW_BALL) ? ball_y : old_by;
         w      = 8'(BALL_SZ);
         h      = 7'(BALL_SZ);
         colour = (code == CODE_DRAW_BALL) ? BALL_COL : BG_COL;
      end
   end

endmodule

// File: rtl/draw_engine.sv
// Latches a new ld_draw code and rasterises its rectangle, one registered pixel per clk.
// Latency: accept at edge N, first pixel and busy from N+1; w*h plot cycles then one DONE cycle.
// Backpressure: none; ld_draw changes are ignored until the rectangle completes and the FSM is back in IDLE.
module draw_engine
   import draw_engine_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic [4:0]  ld_draw,
   input  logic [7:0]  paddle_x,
   input  logic [7:0]  ball_x,
   input  logic [6:0]  ball_y,
   output logic [28:0] busy,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot
);

   state_t     state, state_n;
   logic [4:0] code_q, code_n;
   logic [7:0] x0_q, x0_n, w_q, w_n, cnt_x, cnt_x_n;
   logic [6:0] y0_q, y0_n, h_q, h_n, cnt_y, cnt_y_n;
   logic [2:0] col_q, col_n;
   logic [4:0] last_code, last_code_n;
   logic [7:0] old_px, old_px_n, old_bx, old_bx_n;
   logic [6:0] old_by, old_by_n;
   logic [27:0] busy_hi, busy_hi_n;
   logic [7:0] x_n;
   logic [6:0] y_n;
   logic [2:0] colour_n;
   logic       plot_n;

   logic [7:0] lut_x0, lut_w;
   logic [6:0] lut_y0, lut_h;
   logic [2:0] lut_col;
   logic       accept;
   logic       last_px;

   // Code 0 never executes, so its busy bit is a constant
   assign busy = {busy_hi, 1'b0};

   draw_geom_lut u_geom (
      .code     (ld_draw),
      .paddle_x (paddle_x),
      .ball_x   (ball_x),
      .ball_y   (ball_y),
      .old_px   (old_px),
      .old_bx   (old_bx),
      .old_by   (old_by),
      .x0       (lut_x0),
      .y0       (lut_y0),
      .w        (lut_w),
      .h        (lut_h),
      .colour   (lut_col)
   );

   assign accept  = (state == ST_IDLE) && (ld_draw >= CODE_BRICK_FIRST) &&
                    (ld_draw <= CODE_REMOVE_LAST) && (ld_draw != last_code);
   assign last_px = (cnt_x == w_q - 8'd1) && (cnt_y == h_q - 7'd1);

   // Next-state, counter and registered-output computation
   always_comb begin
      state_n     = state;
      code_n      = code_q;
      x0_n        = x0_q;
      y0_n        = y0_q;
      w_n         = w_q;
      h_n         = h_q;
      col_n       = col_q;
      cnt_x_n     = cnt_x;
      cnt_y_n     = cnt_y;
      last_code_n = last_code;
      old_px_n    = old_px;
      old_bx_n    = old_bx;
      old_by_n    = old_by;
      busy_hi_n   = 28'd0;
      plot_n      = 1'b0;
      x_n         = x;
      y_n         = y;
      colour_n    = colour;
      case (state)
         ST_IDLE: begin
            if (ld_draw == CODE_NONE) begin
               last_code_n = CODE_NONE;
            end
            if (accept) begin
               state_n   = ST_SCAN;
               code_n    = ld_draw;
               x0_n      = lut_x0;
               y0_n      = lut_y0;
               w_n       = lut_w;
               h_n       = lut_h;
               col_n     = lut_col;
               cnt_x_n   = 8'd0;
               cnt_y_n   = 7'd0;
               busy_hi_n = 28'd1 << (ld_draw - 5'd1);
               plot_n    = 1'b1;
               x_n       = lut_x0;
               y_n       = lut_y0;
               colour_n  = lut_col;
            end
         end
         ST_SCAN: begin
            if (last_px) begin
               state_n = ST_DONE;
            end else begin
               if (cnt_x == w_q - 8'd1) begin
                  cnt_x_n = 8'd0;
                  cnt_y_n = cnt_y + 7'd1;
               end else begin
                  cnt_x_n = cnt_x + 8'd1;
               end
               busy_hi_n = busy_hi;
               plot_n    = 1'b1;
               x_n       = x0_q + cnt_x_n;
               y_n       = y0_q + cnt_y_n;
            end
         end
         ST_DONE: begin
            state_n     = ST_IDLE;
            last_code_n = code_q;
            if (code_q == CODE_DRAW_PADDLE) begin
               old_px_n = x0_q;
            end
            if (code_q == CODE_DRAW_BALL) begin
               old_bx_n = x0_q;
               old_by_n = y0_q;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State, command latches and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         code_q    <= 5'd0;
         x0_q      <= 8'd0;
         y0_q      <= 7'd0;
         w_q       <= 8'd0;
         h_q       <= 7'd0;
         col_q     <= 3'd0;
         cnt_x     <= 8'd0;
         cnt_y     <= 7'd0;
         last_code <= CODE_NONE;
         old_px    <= PADDLE_X_INIT;
         old_bx    <= BALL_X_INIT;
         old_by    <= BALL_Y_INIT;
         busy_hi   <= 28'd0;
         plot      <= 1'b0;
         x         <= 8'd0;
         y         <= 7'd0;
         colour    <= 3'd0;
      end else begin
         state     <= state_n;
         code_q    <= code_n;
         x0_q      <= x0_n;
         y0_q      <= y0_n;
         w_q       <= w_n;
         h_q       <= h_n;
         col_q     <= col_n;
         cnt_x     <= cnt_x_n;
         cnt_y     <= cnt_y_n;
         last_code <= last_code_n;
         old_px    <= old_px_n;
         old_bx    <= old_bx_n;
         old_by    <= old_by_n;
         busy_hi   <= busy_hi_n;
         plot      <= plot_n;
         x         <= x_n;
         y         <= y_n;
         colour    <= colour_n;
      end
   end

endmodule

// File: tb/tb_draw_engine.sv
// Self-checking bench for draw_engine: directed scenarios plus random command streams against a rectangle model.
// Latency: checks the first pixel one clock after acceptance and the DONE cycle after the last pixel.
// Backpressure: exercises held codes, mid-scan code changes, ignored codes and mid-scan reset.
module tb_draw_engine;

   logic        clk = 1'b0;
   logic        resetn;
   logic [4:0]  ld_draw;
   logic [7:0]  paddle_x;
   logic [7:0]  ball_x;
   logic [6:0]  ball_y;
   logic [28:0] busy;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int         m_last;
   int         m_old_px, m_old_bx, m_old_by;
   logic [7:0] m_x;
   logic [6:0] m_y;
   logic [2:0] m_col;

   always #10 clk = ~clk;

   draw_engine dut (
      .clk      (clk),
      .resetn   (resetn),
      .ld_draw  (ld_draw),
      .paddle_x (paddle_x),
      .ball_x   (ball_x),
      .ball_y   (ball_y),
      .busy     (busy),
      .x        (x),
      .y        (y),
      .colour   (colour),
      .plot     (plot)
   );

   function automatic logic [47:0] obs();
      return {plot, busy, x, y, colour};
   endfunction

   function automatic logic [47:0] idle_exp();
      return {1'b0, 29'd0, m_x, m_y, m_col};
   endfunction

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got plot=%0b busy=%h x=%0d y=%0d col=%b, expected plot=%0b busy=%h x=%0d y=%0d col=%b",
                  tag, got[47], got[46:18], got[17:10], got[9:3], got[2:0],
                  exp[47], exp[46:18], exp[17:10], exp[9:3], exp[2:0]);
      end
   endtask

   task automatic model_reset();
      m_last   = 0;
      m_old_px = 70;
      m_old_bx = 79;
      m_old_by = 100;
      m_x      = 8'd0;
      m_y      = 7'd0;
      m_col    = 3'd0;
   endtask

   // Rectangle for a code, from the game's geometry rules
   task automatic ref_rect(input int code, output int x0, output int y0, output int w, output int h, output int col);
      int k;
      x0 = 0; y0 = 0; w = 0; h = 0; col = 0;
      if ((code >= 1 && code <= 12) || (code >= 17 && code <= 28)) begin
         k   = (code <= 12) ? code : code - 16;
         x0  = 2 + ((k - 1) % 6) * 26;
         y0  = 10 + ((k - 1) / 6) * 8;
         w   = 24;
         h   = 6;
         col = (code <= 12) ? 4 : 0;
      end else if (code == 13) begin
         x0 = m_old_px; y0 = 112; w = 20; h = 3; col = 0;
      end else if (code == 14) begin
         x0 = int'(paddle_x); y0 = 112; w = 20; h = 3; col = 7;
      end else if (code == 15) begin
         x0 = m_old_bx; y0 = m_old_by; w = 2; h = 2; col = 0;
      end else if (code == 16) begin
         x0 = int'(ball_x); y0 = int'(ball_y); w = 2; h = 2; col = 2;
      end
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check(tag, obs(), idle_exp());
      end
   endtask

   task automatic gap();
      ld_draw = 5'd0;
      idle_cycles(1, "gap");
      m_last = 0;
   endtask

   // Issue a code with the engine idle; optionally switch ld_draw after pixel chg_at
   task automatic exec(input int code, input int chg_at, input int chg_code);
      int x0, y0, w, h, col, idx;
      logic [28:0] b;
      ld_draw = 5'(code);
      if (!(code >= 1 && code <= 28 && code != m_last)) begin
         idle_cycles(3, "no_accept");
         return;
      end
      ref_rect(code, x0, y0, w, h, col);
      b   = 29'd1 << code;
      idx = 0;
      for (int cy = 0; cy < h; cy++) begin
         for (int cx = 0; cx < w; cx++) begin
            @(negedge clk);
            m_x   = 8'(x0 + cx);
            m_y   = 7'(y0 + cy);
            m_col = 3'(col);
            check("pixel", obs(), {1'b1, b, m_x, m_y, m_col});
            if (idx == chg_at) ld_draw = 5'(chg_code);
            idx++;
         end
      end
      @(negedge clk);
      check("done", obs(), idle_exp());
      m_last = code;
      if (code == 14) m_old_px = x0;
      if (code == 16) begin
         m_old_bx = x0;
         m_old_by = y0;
      end
      @(negedge clk);
      check("idle_after", obs(), idle_exp());
   endtask

   initial begin
      int code;
      model_reset();
      resetn   = 1'b0;
      ld_draw  = 5'd0;
      paddle_x = 8'd0;
      ball_x   = 8'd0;
      ball_y   = 7'd0;
      repeat (2) @(negedge clk);
      check("reset", obs(), 48'd0);
      resetn = 1'b1;
      idle_cycles(1, "post_reset");

      // Brick 1, then brick 7 held steady
      exec(1, -1, 0);
      gap();
      exec(7, -1, 0);
      idle_cycles(50, "hold7");
      gap();

      // Paddle erase at init, draw at 30, erase at 30
      exec(13, -1, 0);
      paddle_x = 8'd30;
      exec(14, -1, 0);
      gap();
      exec(13, -1, 0);

      // Ball draw/erase and brick removal
      ball_x = 8'd50;
      ball_y = 7'd60;
      exec(16, -1, 0);
      exec(15, -1, 0);
      exec(20, -1, 0);
      gap();

      // Mid-scan code change: brick 1 completes, then brick 2 runs
      exec(1, 10, 2);
      exec(2, -1, 0);
      exec(30, -1, 0);

      // Reset in the middle of a paddle draw
      paddle_x = 8'd40;
      ld_draw  = 5'd14;
      repeat (6) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("rst_mid", obs(), 48'd0);
      ld_draw = 5'd0;
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      idle_cycles(1, "post_rst_mid");
      exec(13, -1, 0);

      // Random command stream
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) gap();
         paddle_x = 8'($urandom_range(0, 140));
         ball_x   = 8'($urandom_range(0, 158));
         ball_y   = 7'($urandom_range(0, 118));
         if ($urandom_range(0, 4) == 0 && m_last != 0) code = m_last;
         else code = $urandom_range(1, 31);
         exec(code, -1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
